// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared front-end definitions: NOP encoding, default reset PC and fetch FSM states.
package instr_fetch_ctrl_pkg;

  // Canonical RV NOP (addi x0, x0, 0), used by consumers that pad the instruction stream.
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  // Default first fetch address after reset.
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StDrain
  } fetchState_t;

endpackage

// File: rtl/fetch_credit_ctr.sv
// Tracks granted-but-unanswered requests and how many of those responses must be discarded.
module fetch_credit_ctr #(
  parameter int unsigned CntW     = 3,
  parameter int unsigned MaxCount = 2
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            inc,
  input  logic            dec,
  input  logic            load,
  output logic [CntW-1:0] outstanding,
  output logic [CntW-1:0] drop,
  output logic [CntW-1:0] dropNext
);

  logic [CntW-1:0] outstandingNext;

  // Next-state: outstanding follows grants/responses; a load marks everything still in flight
  // (excluding a response retiring this cycle) as stale.
  always_comb begin
    outstandingNext = outstanding + CntW'(inc) - CntW'(dec);
    dropNext        = drop;
    if (load) begin
      dropNext = outstandingNext;
    end else if (dec && (drop != '0)) begin
      dropNext = drop - CntW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstandingNext;
      drop        <= dropNext;
    end
  end

  // A grant past the limit or a response with nothing in flight means the issue logic is broken.
  assert property (@(posedge clock) disable iff (!resetn) inc |-> (outstanding < CntW'(MaxCount)));
  assert property (@(posedge clock) disable iff (!resetn) dec |-> (outstanding != '0));
  assert property (@(posedge clock) disable iff (!resetn) (dec && !load) |-> (drop <= outstanding));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: issues in-order word requests under a credit limit, pushes returned words
// into the instruction buffer and discards stale responses after a redirect.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(ResetPcDefault),
  parameter int unsigned     BUF_DEPTH       = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       fetchEn,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirectPc,
  output logic                       iReq,
  output logic [XLEN-1:0]            iAddr,
  input  logic                       iGnt,
  input  logic                       iRvalid,
  input  logic [31:0]                iRdata,
  input  logic [$clog2(BUF_DEPTH):0] bufFreeSlots,
  output logic                       bufFlush,
  output logic                       bufPush,
  output logic [29:0]                bufInstr,
  output logic [XLEN-1:0]            bufIAddr
);

  localparam int unsigned CntW = $clog2(BUF_DEPTH) + 1;

  fetchState_t     state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] respPc;
  logic [XLEN-1:0] alignedRedirect;
  logic [CntW-1:0] outstanding;
  logic [CntW-1:0] drop;
  logic [CntW-1:0] dropNext;
  logic            issue;
  logic            unusedLowBits;

  assign alignedRedirect = {redirectPc[XLEN-1:2], 2'b00};
  assign issue           = iReq & iGnt;
  // Byte-offset bits carry no information for word fetches.
  assign unusedLowBits   = ^{redirectPc[1:0], iRdata[1:0]};

  fetch_credit_ctr #(
    .CntW     (CntW),
    .MaxCount (MAX_OUTSTANDING)
  ) uCredit (
    .clock       (clock),
    .resetn      (resetn),
    .inc         (issue),
    .dec         (iRvalid),
    .load        (redirect),
    .outstanding (outstanding),
    .drop        (drop),
    .dropNext    (dropNext)
  );

  // Request and buffer-side outputs; credit check keeps every accepted request backed by space.
  always_comb begin
    iReq     = (state == StFetch) & fetchEn & ~redirect &
               (outstanding < CntW'(MAX_OUTSTANDING)) & (outstanding < bufFreeSlots);
    iAddr    = pc;
    bufFlush = redirect;
    bufPush  = iRvalid & ~redirect & (drop == '0);
    bufInstr = bufPush ? iRdata[31:2] : '0;
    bufIAddr = bufPush ? respPc : '0;
  end

  // Sequencer state: redirect overrides everything, else advance PCs and step the FSM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= StBoot;
      pc     <= RESET_PC;
      respPc <= RESET_PC;
    end else if (redirect) begin
      pc     <= alignedRedirect;
      respPc <= alignedRedirect;
      state  <= (dropNext != '0) ? StDrain : StFetch;
    end else begin
      if (issue) begin
        pc <= pc + XLEN'(4);
      end
      if (bufPush) begin
        respPc <= respPc + XLEN'(4);
      end
      unique case (state)
        StBoot:  state <= StFetch;
        StFetch: state <= StFetch;
        StDrain: if (dropNext == '0) state <= StFetch;
        default: state <= StBoot;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench: the bench plays memory and buffer, predicts pushes from request epochs.
module tb_instr_fetch_ctrl;

  localparam int unsigned  MaxOut  = 2;
  localparam logic [31:0]  ResetPc = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        fetchEn = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        iReq;
  logic [31:0] iAddr;
  logic        iGnt = 1'b0;
  logic        iRvalid = 1'b0;
  logic [31:0] iRdata = '0;
  logic [2:0]  bufFreeSlots = 3'd4;
  logic        bufFlush;
  logic        bufPush;
  logic [29:0] bufInstr;
  logic [31:0] bufIAddr;

  instr_fetch_ctrl #(
    .XLEN            (32),
    .RESET_PC        (ResetPc),
    .BUF_DEPTH       (4),
    .MAX_OUTSTANDING (MaxOut)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .fetchEn      (fetchEn),
    .redirect     (redirect),
    .redirectPc   (redirectPc),
    .iReq         (iReq),
    .iAddr        (iAddr),
    .iGnt         (iGnt),
    .iRvalid      (iRvalid),
    .iRdata       (iRdata),
    .bufFreeSlots (bufFreeSlots),
    .bufFlush     (bufFlush),
    .bufPush      (bufPush),
    .bufInstr     (bufInstr),
    .bufIAddr     (bufIAddr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          epoch;
    int          readyCyc;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [29:0] instr;
  } push_t;

  req_t  inflight[$];
  push_t sbq[$];
  push_t popped;

  int          nChecks = 0;
  int          nErrors = 0;
  int          cyc = 0;
  int          mEpoch = 0;
  logic [31:0] mPc = ResetPc;
  bit          mBoot = 1'b1;
  bit          armed = 1'b0;
  bit          inReset = 1'b1;
  bit          expReq = 1'b0;
  bit          expFlush = 1'b0;
  bit          expPush = 1'b0;
  logic [31:0] expAddr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against what the driver predicted.
  always @(negedge clock) begin
    if (armed) begin
      if (inReset) begin
        chk("rst_iReq", 64'(iReq), 64'd0);
        chk("rst_iAddr", 64'(iAddr), 64'(ResetPc));
        chk("rst_bufPush", 64'(bufPush), 64'd0);
        chk("rst_bufFlush", 64'(bufFlush), 64'd0);
        chk("rst_bufInstr", 64'(bufInstr), 64'd0);
        chk("rst_bufIAddr", 64'(bufIAddr), 64'd0);
      end else begin
        chk("iReq", 64'(iReq), 64'(expReq));
        if (expReq && iReq) chk("iAddr", 64'(iAddr), 64'(expAddr));
        chk("bufFlush", 64'(bufFlush), 64'(expFlush));
        chk("bufPush", 64'(bufPush), 64'(expPush));
        if (expPush && sbq.size() > 0) begin
          popped = sbq.pop_front();
          if (bufPush) begin
            chk("bufIAddr", 64'(bufIAddr), 64'(popped.addr));
            chk("bufInstr", 64'(bufInstr), 64'(popped.instr));
          end
        end
      end
    end
  end

  task automatic resetCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
      resetn       = 1'b0;
      fetchEn      = 1'b0;
      redirect     = 1'b0;
      iGnt         = 1'b0;
      iRvalid      = 1'b0;
      iRdata       = $urandom;
      bufFreeSlots = 3'd4;
      inflight.delete();
      sbq.delete();
      mPc      = ResetPc;
      mEpoch   = 0;
      mBoot    = 1'b1;
      expReq   = 1'b0;
      expFlush = 1'b0;
      expPush  = 1'b0;
      inReset  = 1'b1;
      armed    = 1'b1;
    end
  endtask

  // One cycle of stimulus plus the reference prediction for that cycle.
  task automatic runCycle(input int pEn, input int pGnt, input int pRv, input int latMin,
                          input int latMax, input int freeMin, input int freeMax,
                          input int pRedir, input bit forceRedir, input logic [31:0] forcePc);
    int  stale;
    bit  rv;
    req_t r;
    @(posedge clock);
    #1;
    cyc++;
    if (!resetn) begin
      resetn  = 1'b1;
      inReset = 1'b0;
    end
    fetchEn      = ($urandom_range(99) < pEn);
    redirect     = forceRedir || ($urandom_range(99) < pRedir);
    redirectPc   = forceRedir ? forcePc : $urandom;
    iGnt         = ($urandom_range(99) < pGnt);
    bufFreeSlots = 3'($urandom_range(freeMax, freeMin));
    stale = 0;
    foreach (inflight[i]) if (inflight[i].epoch != mEpoch) stale++;
    rv = 1'b0;
    if (inflight.size() > 0) rv = (inflight[0].readyCyc <= cyc) && ($urandom_range(99) < pRv);
    iRvalid = rv;
    iRdata  = rv ? inflight[0].data : $urandom;

    expReq   = !mBoot && fetchEn && !redirect && (inflight.size() < MaxOut) &&
               (inflight.size() < int'(bufFreeSlots)) && (stale == 0);
    expAddr  = mPc;
    expFlush = redirect;
    expPush  = 1'b0;
    if (rv) begin
      r = inflight.pop_front();
      expPush = !redirect && (r.epoch == mEpoch);
      if (expPush) sbq.push_back('{addr: r.addr, instr: r.data[31:2]});
    end
    if (expReq && iGnt) begin
      inflight.push_back('{addr: mPc, data: $urandom, epoch: mEpoch,
                           readyCyc: cyc + 1 + int'($urandom_range(latMax, latMin))});
      mPc = mPc + 32'd4;
    end
    if (redirect) begin
      mEpoch++;
      mPc = {redirectPc[31:2], 2'b00};
    end
    mBoot = 1'b0;
  endtask

  initial begin
    resetCycles(2);

    // Back-to-back streaming, one-cycle memory latency, plenty of buffer space.
    repeat (20) runCycle(100, 100, 100, 0, 0, 4, 4, 0, 1'b0, '0);

    // Single free slot and three-cycle latency: at most one request in flight.
    repeat (30) runCycle(100, 100, 100, 2, 2, 1, 1, 0, 1'b0, '0);

    // Fill two outstanding requests, then redirect to an unaligned target.
    for (int i = 0; i < 12 && inflight.size() < 2; i++)
      runCycle(100, 100, 0, 3, 3, 4, 4, 0, 1'b0, '0);
    runCycle(100, 100, 0, 3, 3, 4, 4, 0, 1'b1, 32'h0000_0103);
    repeat (15) runCycle(100, 100, 100, 0, 1, 4, 4, 0, 1'b0, '0);

    // Drop fetchEn with requests in flight, then resume.
    for (int i = 0; i < 12 && inflight.size() < 2; i++)
      runCycle(100, 100, 0, 2, 2, 4, 4, 0, 1'b0, '0);
    repeat (8) runCycle(0, 100, 100, 0, 0, 4, 4, 0, 1'b0, '0);
    repeat (10) runCycle(100, 100, 100, 0, 0, 4, 4, 0, 1'b0, '0);

    // Randomized traffic with redirects, stalls and varying credit.
    repeat (400) runCycle(80, 70, 60, 0, 3, 0, 4, 5, 1'b0, '0);

    // Reset while draining stale responses.
    for (int i = 0; i < 12 && inflight.size() < 2; i++)
      runCycle(100, 100, 0, 3, 3, 4, 4, 0, 1'b0, '0);
    runCycle(100, 100, 0, 3, 3, 4, 4, 0, 1'b1, 32'h0000_2000);
    resetCycles(2);
    repeat (15) runCycle(100, 100, 100, 0, 0, 4, 4, 0, 1'b0, '0);

    // Let remaining responses complete.
    for (int i = 0; i < 40 && inflight.size() > 0; i++)
      runCycle(0, 0, 100, 0, 0, 4, 4, 0, 1'b0, '0);
    @(posedge clock);
    #1;
    armed = 1'b0;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
